// File: rtl/hub75_pkg.sv
// hub75_pkg: panel geometry, fb_data field layout and the pixel word shared by the
// HUB75 fetch and shifter blocks.
package hub75_pkg;
  localparam int COLS = 32;
  localparam int ROWS_HALF = 16;
  localparam int PLANES = 4;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS_HALF);
  localparam int PW = $clog2(PLANES);
  localparam int AW = RW + CW;
  localparam int FBW = 6 * PLANES;
  localparam int TOP_R = 0;
  localparam int TOP_G = PLANES;
  localparam int TOP_B = 2 * PLANES;
  localparam int BOT_R = 3 * PLANES;
  localparam int BOT_G = 4 * PLANES;
  localparam int BOT_B = 5 * PLANES;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic last;
  } pix_t;

  localparam int PIX_W = $bits(pix_t);

  // Returns {bottom, top} bit of one colour channel for bit-plane p.
  function automatic logic [1:0] plane_bits(input logic [FBW-1:0] d, input int top, input int bot,
                                            input logic [PW-1:0] p);
    logic [FBW-1:0] ts, bs;
    logic [PLANES-1:0] tn, bn;
    ts = d >> top;
    bs = d >> bot;
    tn = ts[PLANES-1:0];
    bn = bs[PLANES-1:0];
    return {bn[p], tn[p]};
  endfunction
endpackage

// File: rtl/hub75_skid_fifo.sv
// hub75_skid_fifo: 2-entry FIFO whose head register drives the output directly.
module hub75_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic pop_v;
  logic [1:0] wr;

  assign pop_v = pop && valid;
  assign wr = count - {1'b0, pop_v};
  assign valid = count != 2'd0;
  assign dout = mem[0];

  always_ff @(posedge clk)
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count <= '0;
    end else begin
      if (pop_v) mem[0] <= mem[1];
      if (push) mem[wr[0]] <= din;
      count <= count + {1'b0, push} - {1'b0, pop_v};
    end
endmodule

// File: rtl/hub75_pixel_fetch.sv
// hub75_pixel_fetch: walks the framebuffer in scan order (row, plane, col) and streams the
// current bit-plane of each top/bottom pixel pair to the panel shifter.
module hub75_pixel_fetch
  import hub75_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             fb_rd,
  output logic [AW-1:0]    fb_addr,
  input  logic [FBW-1:0]   fb_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [1:0]       pix_r,
  output logic [1:0]       pix_g,
  output logic [1:0]       pix_b,
  output logic [RW-1:0]    pix_row,
  output logic [PW-1:0]    pix_plane,
  output logic             pix_last,
  output logic             frame_done
);
  state_t state;
  logic [CW-1:0] col;
  logic [PW-1:0] plane, plane_d;
  logic [RW-1:0] row, row_d;
  logic stop, vld_d, last_d, pop;
  logic [1:0] count;
  logic [2:0] used;
  pix_t din, head;

  assign pop = pix_valid && pix_ready;
  // Words already owed to the FIFO after this cycle's pop; a new read needs one free slot.
  assign used = {1'b0, count} + {2'b0, vld_d} - {2'b0, pop};
  assign fb_rd = rst && state == FETCH && used < 3'd2;
  assign fb_addr = {row, col};
  assign din = '{r: plane_bits(fb_data, TOP_R, BOT_R, plane_d),
                 g: plane_bits(fb_data, TOP_G, BOT_G, plane_d),
                 b: plane_bits(fb_data, TOP_B, BOT_B, plane_d),
                 row: row_d, plane: plane_d, last: last_d};
  assign {pix_r, pix_g, pix_b, pix_row, pix_plane, pix_last} = head;

  hub75_skid_fifo #(.W(PIX_W)) u_fifo (
    .clk(clk), .rst(rst), .push(vld_d), .din(din), .pop(pop),
    .dout(head), .valid(pix_valid), .count(count)
  );

  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      col <= '0;
      plane <= '0;
      row <= '0;
      stop <= 1'b0;
      vld_d <= 1'b0;
      row_d <= '0;
      plane_d <= '0;
      last_d <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vld_d <= fb_rd;
      frame_done <= pop && head.last && head.row == RW'(ROWS_HALF - 1) && head.plane == PW'(PLANES - 1);
      if (fb_rd) begin
        row_d <= row;
        plane_d <= plane;
        last_d <= col == CW'(COLS - 1);
        col <= col + CW'(1);
        if (col == CW'(COLS - 1)) begin
          plane <= plane == PW'(PLANES - 1) ? '0 : plane + PW'(1);
          if (plane == PW'(PLANES - 1)) row <= row + RW'(1);
        end
      end
      case (state)
        IDLE: begin
          stop <= 1'b0;
          if (en) state <= FETCH;
        end
        // A stop request only takes effect once the row-plane's last column is issued.
        FETCH: begin
          if (!en) stop <= 1'b1;
          if (fb_rd && col == CW'(COLS - 1) && (stop || !en)) state <= DRAIN;
        end
        DRAIN: if (count == 2'd0 && !vld_d) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hub75_pixel_fetch.sv
// tb_hub75_pixel_fetch: directed vectors plus a scan-order scoreboard for hub75_pixel_fetch.
module tb_hub75_pixel_fetch;
  import hub75_pkg::*;

  typedef logic [PIX_W-1:0] word_t;
  typedef struct {
    int m;
    int idx;
    word_t w;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, pix_ready = 1'b0;
  logic fb_rd, pix_valid, pix_last, frame_done;
  logic [AW-1:0] fb_addr;
  logic [FBW-1:0] fb_data = '0;
  logic [1:0] pix_r, pix_g, pix_b;
  logic [RW-1:0] pix_row;
  logic [PW-1:0] pix_plane;

  int checks = 0, failures = 0, mode = 0;
  int rd_cnt, xfer_cnt, erow, eplane, ecol, fd_count, fd_xfers;
  bit final_prev, pv, pr;
  word_t pw, cur;
  word_t cap0 [2112];
  word_t cap1 [2112];
  vec_t vecs [20];

  hub75_pixel_fetch dut (
    .clk(clk), .rst(rst), .en(en), .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_row(pix_row), .pix_plane(pix_plane), .pix_last(pix_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [FBW-1:0] mem_data(input logic [AW-1:0] a, input int m);
    if (m == 0) return {6{a[3:0]}};
    return {4'b0011, ~a[3:0], 4'b0101, a[7:4], a[3:0], 4'b1010};
  endfunction

  function automatic word_t exp_word(input int m, input int r, input int p, input int c);
    logic [FBW-1:0] d;
    d = mem_data(AW'(r * COLS + c), m) >> p;
    return {d[BOT_R], d[TOP_R], d[BOT_G], d[TOP_G], d[BOT_B], d[TOP_B], RW'(r), PW'(p), c == COLS - 1};
  endfunction

  function automatic word_t mkw(input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                                input int row, input int plane, input logic last);
    return {r, g, b, RW'(row), PW'(plane), last};
  endfunction

  always @(posedge clk) if (fb_rd) fb_data <= mem_data(fb_addr, mode);

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_fb_rd"}, 32'(fb_rd), 0);
    chk({n, "_fb_addr"}, 32'(fb_addr), 0);
    chk({n, "_valid"}, 32'(pix_valid), 0);
    chk({n, "_word"}, 32'({pix_r, pix_g, pix_b, pix_row, pix_plane, pix_last}), 0);
    chk({n, "_frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: scoreboard in scan order, handshake stability, credit and frame_done checks.
  initial forever begin
    @(negedge clk);
    cur = {pix_r, pix_g, pix_b, pix_row, pix_plane, pix_last};
    if (!rst) begin
      rd_cnt = 0; xfer_cnt = 0; erow = 0; eplane = 0; ecol = 0;
      fd_count = 0; fd_xfers = 0; final_prev = 0; pv = 0; pr = 0;
    end else begin
      if (frame_done || final_prev) begin
        chk("frame_done", 32'(frame_done), 32'(final_prev));
        if (frame_done) begin fd_count++; fd_xfers = xfer_cnt; end
      end
      if (pv && !pr) begin
        chk("hold_valid", 32'(pix_valid), 1);
        chk("hold_data", 32'(cur), 32'(pw));
      end
      if (fb_rd) begin
        chk("credit", 32'(rd_cnt - xfer_cnt - int'(pix_valid && pix_ready) < 2), 1);
        rd_cnt++;
      end
      final_prev = 0;
      if (pix_valid && pix_ready) begin
        chk("word", 32'(cur), 32'(exp_word(mode, erow, eplane, ecol)));
        if (xfer_cnt < 2112) begin
          if (mode == 0) cap0[xfer_cnt] = cur;
          else cap1[xfer_cnt] = cur;
        end
        final_prev = erow == ROWS_HALF - 1 && eplane == PLANES - 1 && ecol == COLS - 1;
        xfer_cnt++;
        ecol++;
        if (ecol == COLS) begin
          ecol = 0;
          eplane++;
          if (eplane == PLANES) begin
            eplane = 0;
            erow = (erow + 1) % ROWS_HALF;
          end
        end
      end
      pv = pix_valid;
      pr = pix_ready;
      pw = cur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int n, q, gaps;
    vecs[0]  = '{0, 0,    mkw(2'b00, 2'b00, 2'b00, 0, 0, 0)};
    vecs[1]  = '{0, 1,    mkw(2'b11, 2'b11, 2'b11, 0, 0, 0)};
    vecs[2]  = '{0, 2,    mkw(2'b00, 2'b00, 2'b00, 0, 0, 0)};
    vecs[3]  = '{0, 31,   mkw(2'b11, 2'b11, 2'b11, 0, 0, 1)};
    vecs[4]  = '{0, 33,   mkw(2'b00, 2'b00, 2'b00, 0, 1, 0)};
    vecs[5]  = '{0, 34,   mkw(2'b11, 2'b11, 2'b11, 0, 1, 0)};
    vecs[6]  = '{0, 68,   mkw(2'b11, 2'b11, 2'b11, 0, 2, 0)};
    vecs[7]  = '{0, 103,  mkw(2'b00, 2'b00, 2'b00, 0, 3, 0)};
    vecs[8]  = '{0, 104,  mkw(2'b11, 2'b11, 2'b11, 0, 3, 0)};
    vecs[9]  = '{0, 128,  mkw(2'b00, 2'b00, 2'b00, 1, 0, 0)};
    vecs[10] = '{0, 2047, mkw(2'b11, 2'b11, 2'b11, 15, 3, 1)};
    vecs[11] = '{0, 2048, mkw(2'b00, 2'b00, 2'b00, 0, 0, 0)};
    vecs[12] = '{1, 0,    mkw(2'b10, 2'b10, 2'b10, 0, 0, 0)};
    vecs[13] = '{1, 19,   mkw(2'b10, 2'b01, 2'b11, 0, 0, 0)};
    vecs[14] = '{1, 32,   mkw(2'b01, 2'b10, 2'b10, 0, 1, 0)};
    vecs[15] = '{1, 48,   mkw(2'b01, 2'b10, 2'b10, 0, 1, 0)};
    vecs[16] = '{1, 64,   mkw(2'b10, 2'b10, 2'b00, 0, 2, 0)};
    vecs[17] = '{1, 96,   mkw(2'b01, 2'b10, 2'b00, 0, 3, 0)};
    vecs[18] = '{1, 479,  mkw(2'b10, 2'b01, 2'b01, 3, 2, 1)};
    vecs[19] = '{1, 480,  mkw(2'b01, 2'b10, 2'b00, 3, 3, 0)};

    repeat (3) step();
    chk_reset("rst_init");
    rst = 1'b1; en = 1'b1; pix_ready = 1'b1;

    n = 0;
    while (!fb_rd && n < 20) begin step(); n++; end
    chk("first_rd", 32'(fb_rd), 1);
    chk("first_addr", 32'(fb_addr), 0);
    n = 0;
    do begin step(); n++; end while (!pix_valid && n < 10);
    chk("latency", 32'(n), 2);
    gaps = 0;
    repeat (40) begin step(); if (!pix_valid) gaps++; end
    chk("stream_gaps", 32'(gaps), 0);

    n = 0;
    while (fd_count == 0 && n < 3000) begin step(); n++; end
    chk("frame_done_seen", 32'(fd_count), 1);
    chk("frame_xfers", 32'(fd_xfers), 2048);
    repeat (20) step();
    chk("frame_done_once", 32'(fd_count), 1);

    repeat (1500) begin step(); pix_ready = 1'($urandom_range(0, 1)); end

    pix_ready = 1'b0;
    repeat (6) step();
    chk("full_valid", 32'(pix_valid), 1);
    rst = 1'b0;
    step();
    chk_reset("rst_mid");
    mode = 1; pix_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("no_valid_after_rst", 32'(pix_valid), 0);

    n = 0;
    while (rd_cnt < 458 && n < 1000) begin step(); n++; end
    en = 1'b0;
    q = 0; n = 0;
    while (q < 4 && n < 200) begin
      step(); n++;
      q = (fb_rd || pix_valid) ? 0 : q + 1;
    end
    chk("quiet", 32'(q >= 4), 1);
    chk("stop_reads", 32'(rd_cnt), 480);
    chk("drained", 32'(xfer_cnt), 480);
    en = 1'b1;
    n = 0;
    while (xfer_cnt <= 480 && n < 50) begin step(); n++; end
    chk("resume", 32'(xfer_cnt > 480), 1);

    for (int i = 0; i < 20; i++)
      chk($sformatf("vec%0d", i), 32'(vecs[i].m == 0 ? cap0[vecs[i].idx] : cap1[vecs[i].idx]), 32'(vecs[i].w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
